button_autorepeat: RTL and testbench
====================================

# button_autorepeat

Debounced push-button front end with hold-to-repeat, sitting between a raw board button (BTNU/BTND) and the colour-level up/down logic that steps the red/green/blue PWM levels. It synchronises and debounces the raw input and emits one single-cycle `PULSE` per press. While the button is held it also emits repeat pulses, so a held button sweeps a level instead of needing one press per step. All outputs are registered in the `CLK100MHZ` domain.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000 (10 ms): consecutive stable cycles required to accept a level change; ≥1.
- `REPEAT_DELAY_CYCLES`, default 50_000_000 (500 ms): cycles from the press pulse to the first repeat pulse; ≥1.
- `REPEAT_PERIOD_CYCLES`, default 10_000_000 (100 ms): cycles between subsequent repeat pulses; ≥2.

Ports:
- `CLK100MHZ` in 1: sole clock.
- `RESET` in 1: asynchronous, active-high reset.
- `BTN_IN` in 1: raw, asynchronous, bouncing button level (1 = pressed).
- `PULSE` out 1: one-cycle strobe on each accepted press and each repeat.
- `HELD` out 1: debounced button level.
- `REPEATING` out 1: high while in the REPEAT state.

## Operation
- **Synchroniser:** two flip-flops. `BTN_IN` → `s1` → `s2`; both reset to 0.
- **Debouncer:** counter `dcnt`, width `$clog2(DEBOUNCE_CYCLES+1)`.
  - Any cycle with `s2 == HELD` clears `dcnt`.
  - Otherwise `dcnt` increments.
  - When `dcnt == DEBOUNCE_CYCLES-1` and `s2 != HELD`, `HELD <= s2` and `dcnt <= 0`.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `HELD`.
- **FSM:** states IDLE, DELAY, REPEAT. One counter `rcnt` is shared, sized for `REPEAT_DELAY_CYCLES`; it is loaded with 0 on every state entry and on every pulse.
  - **IDLE:** on debounced rise (`HELD` going 0→1), assert `PULSE` and go to DELAY.
  - **DELAY:** `rcnt` counts up. When `rcnt == REPEAT_DELAY_CYCLES-1`, assert `PULSE` and go to REPEAT.
  - **REPEAT:** when `rcnt == period-1`, assert `PULSE` and reload `rcnt`. The period is `REPEAT_PERIOD_CYCLES` (see Configuration).
  - **DELAY/REPEAT on debounced fall:** go to IDLE on the same edge that clears `HELD`, with no pulse. A fall wins over a coincident repeat terminal count, so no pulse is produced.
- `REPEATING` = (state == REPEAT), registered.
- **Release:** never produces a pulse.

## Timing
- **Reset values:** `PULSE`, `HELD` and `REPEATING` are 0. The FSM is in IDLE and `s1`, `s2`, `dcnt`, `rcnt` and the repeat count are 0. Values apply immediately on `RESET` assertion, with no clock needed.
- **Reset mid-operation:** outputs drop asynchronously. After release, a still-pressed button is treated as a new press: `PULSE` fires `DEBOUNCE_CYCLES+2` edges after `RESET` deasserts.
- **Press latency:** `BTN_IN` is first sampled high at edge E, with stable input. `HELD` and the first `PULSE` go high at edge `E+DEBOUNCE_CYCLES+1`, in the same cycle.
- **Release latency:** `HELD` falls at the same offset after the falling edge is sampled.
- **Repeat timing:** with the first pulse at cycle T:
  - first repeat at `T+REPEAT_DELAY_CYCLES`;
  - then every `REPEAT_PERIOD_CYCLES` cycles.
- **`PULSE` width:** exactly one cycle; never high on two consecutive cycles.

## Configuration
- **`BUTTON_AUTOREPEAT_ACCEL_EN` defined:** an internal 4-bit repeat count increments on each REPEAT-state pulse and saturates at 8.
  - Once it reaches 8, the period becomes `REPEAT_PERIOD_CYCLES>>1`.
  - The count clears on entry to IDLE and on reset.
- **Macro undefined:** the period is always `REPEAT_PERIOD_CYCLES`. The count logic is absent.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY_CYCLES`=20, `REPEAT_PERIOD_CYCLES`=5.

- **Reset:** hold `RESET`=1 with `BTN_IN`=1 → all outputs stay 0. Deassert `RESET` → `HELD`=1 and one `PULSE` exactly 6 edges later.
- **Glitch rejection:** `BTN_IN` high for 3 cycles, then low → `HELD` stays 0, zero pulses. Then high for 4+2 cycles → exactly one pulse.
- **Hold with repeat:** clean press, released so that `HELD` falls 37 cycles after the first pulse at T → pulses at T, T+20, T+25, T+30, T+35 (5 total). `REPEATING`=1 from T+21 until `HELD` falls. No pulse on release.
- **Release during DELAY:** `HELD` falls at T+12 → no further pulses and the FSM is in IDLE. A re-press gives a fresh first pulse, and its first repeat comes a full 20 cycles later.
- **Reset in REPEAT:** pulse `RESET` at T+27 → `PULSE`/`REPEATING` drop immediately. With `BTN_IN` still high, the next pulse comes 6 edges after `RESET` deasserts.
- **Acceleration (with `BUTTON_AUTOREPEAT_ACCEL_EN`):** long hold → the first 8 repeat pulses are 5 cycles apart (after the 20-cycle delay), all later ones 2 cycles apart. Without the macro, all are 5 apart.

Source files
------------

// File: rtl/button_autorepeat.sv
// button_autorepeat: synchronised, debounced push-button with hold-to-repeat.
// A press gives one PULSE. Holding the button gives a first repeat after
// REPEAT_DELAY_CYCLES, then one every REPEAT_PERIOD_CYCLES.
// Optional macro BUTTON_AUTOREPEAT_ACCEL_EN: after 8 pulses in the REPEAT
// state the repeat period is halved.
module button_autorepeat #(
    parameter int DEBOUNCE_CYCLES      = 1_000_000,
    parameter int REPEAT_DELAY_CYCLES  = 50_000_000,
    parameter int REPEAT_PERIOD_CYCLES = 10_000_000
) (
    input  logic CLK100MHZ,
    input  logic RESET,
    input  logic BTN_IN,
    output logic PULSE,
    output logic HELD,
    output logic REPEATING
);

    localparam int DCW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int RMAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                          REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int RCW  = $clog2(RMAX + 1);

    localparam logic [DCW-1:0] DEB_LAST    = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCW-1:0] DELAY_LAST  = RCW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RCW-1:0] PERIOD_LAST = RCW'(REPEAT_PERIOD_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    logic           s1_q, s2_q;
    logic           held_q, held_d;
    logic [DCW-1:0] dcnt_q, dcnt_d;
    logic [1:0]     state_q, state_d;
    logic [RCW-1:0] rcnt_q, rcnt_d;
    logic           pulse_q, pulse_d;
    logic           repeating_q, repeating_d;
    logic           rise, fall;
    logic [RCW-1:0] period_last;

`ifdef BUTTON_AUTOREPEAT_ACCEL_EN
    localparam logic [RCW-1:0] FAST_LAST = RCW'((REPEAT_PERIOD_CYCLES >> 1) - 1);
    logic [3:0] rep_cnt_q, rep_cnt_d;

    // Repeat period: halved once eight REPEAT-state pulses have been produced.
    always_comb begin
        period_last = (rep_cnt_q == 4'd8) ? FAST_LAST : PERIOD_LAST;
    end
`else
    // Repeat period: fixed.
    always_comb begin
        period_last = PERIOD_LAST;
    end
`endif

    // Debouncer: accept s2 once it has differed from HELD for DEBOUNCE_CYCLES
    // consecutive edges; rise/fall flag the edge on which HELD changes so the
    // FSM reacts in the same cycle.
    always_comb begin
        held_d = held_q;
        dcnt_d = '0;
        rise   = 1'b0;
        fall   = 1'b0;
        if (s2_q != held_q) begin
            if (dcnt_q == DEB_LAST) begin
                held_d = s2_q;
                rise   = s2_q;
                fall   = ~s2_q;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end
    end

    // Press/repeat FSM: rcnt restarts on every state entry and every pulse;
    // a debounced fall always wins over a coincident terminal count.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        pulse_d = 1'b0;
`ifdef BUTTON_AUTOREPEAT_ACCEL_EN
        rep_cnt_d = rep_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                rcnt_d = '0;
`ifdef BUTTON_AUTOREPEAT_ACCEL_EN
                rep_cnt_d = '0;
`endif
                if (rise) begin
                    pulse_d = 1'b1;
                    state_d = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    rcnt_d  = '0;
`ifdef BUTTON_AUTOREPEAT_ACCEL_EN
                    rep_cnt_d = '0;
`endif
                end else if (rcnt_q == DELAY_LAST) begin
                    pulse_d = 1'b1;
                    state_d = ST_REPEAT;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            ST_REPEAT: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    rcnt_d  = '0;
`ifdef BUTTON_AUTOREPEAT_ACCEL_EN
                    rep_cnt_d = '0;
`endif
                end else if (rcnt_q == period_last) begin
                    pulse_d = 1'b1;
                    rcnt_d  = '0;
`ifdef BUTTON_AUTOREPEAT_ACCEL_EN
                    if (rep_cnt_q != 4'd8) begin
                        rep_cnt_d = rep_cnt_q + 4'd1;
                    end
`endif
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rcnt_d  = '0;
            end
        endcase
    end

    // REPEATING reflects the registered state, so it lags entry by one cycle.
    always_comb begin
        repeating_d = (state_q == ST_REPEAT);
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge CLK100MHZ or posedge RESET) begin
        if (RESET) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            held_q      <= 1'b0;
            dcnt_q      <= '0;
            state_q     <= ST_IDLE;
            rcnt_q      <= '0;
            pulse_q     <= 1'b0;
            repeating_q <= 1'b0;
        end else begin
            s1_q        <= BTN_IN;
            s2_q        <= s1_q;
            held_q      <= held_d;
            dcnt_q      <= dcnt_d;
            state_q     <= state_d;
            rcnt_q      <= rcnt_d;
            pulse_q     <= pulse_d;
            repeating_q <= repeating_d;
        end
    end

`ifdef BUTTON_AUTOREPEAT_ACCEL_EN
    // Repeat-count register for the acceleration feature.
    always_ff @(posedge CLK100MHZ or posedge RESET) begin
        if (RESET) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
        end
    end
`endif

    assign PULSE     = pulse_q;
    assign HELD      = held_q;
    assign REPEATING = repeating_q;

endmodule

// File: tb/tb_button_autorepeat.sv
// Testbench for button_autorepeat: directed scenarios plus random presses,
// checked every cycle against a timeline-based reference model.
module tb_button_autorepeat;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int P  = 5;

    logic CLK100MHZ = 1'b0;
    logic RESET     = 1'b0;
    logic BTN_IN    = 1'b0;
    logic PULSE, HELD, REPEATING;

    int n_assert = 0;
    int n_fail   = 0;
    int pulses   = 0;

    button_autorepeat #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY_CYCLES(RD),
        .REPEAT_PERIOD_CYCLES(P)
    ) dut (
        .CLK100MHZ(CLK100MHZ),
        .RESET(RESET),
        .BTN_IN(BTN_IN),
        .PULSE(PULSE),
        .HELD(HELD),
        .REPEATING(REPEATING)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    // Reference model: input pipeline, sample history, time since press.
    bit m_s1, m_s2, m_held, m_active, m_inrep, m_rep, m_pulse;
    int m_t;
    bit hist[$];

    function automatic void model_reset();
        m_s1 = 0; m_s2 = 0; m_held = 0; m_active = 0;
        m_inrep = 0; m_rep = 0; m_pulse = 0; m_t = 0;
        hist.delete();
    endfunction

    // Is offset t (cycles after the press pulse) a repeat-pulse instant?
    function automatic bit pulse_due(int t);
        int k;
        if (t < RD) return 0;
        k = t - RD;
`ifdef BUTTON_AUTOREPEAT_ACCEL_EN
        if (k <= 8 * P) return (k % P) == 0;
        return ((k - 8 * P) % (P / 2)) == 0;
`else
        return (k % P) == 0;
`endif
    endfunction

    function automatic void model_step(bit b);
        bit x, accept, rise, fall;
        x = m_s2;
        hist.push_back(x);
        if (hist.size() > D) void'(hist.pop_front());
        accept = (hist.size() == D);
        foreach (hist[i]) if (hist[i] == m_held) accept = 0;
        rise = accept && x;
        fall = accept && !x;
        if (accept) m_held = x;
        m_rep   = m_inrep;
        m_pulse = 0;
        if (rise) begin
            m_active = 1; m_t = 0; m_pulse = 1;
        end else if (fall) begin
            m_active = 0;
        end else if (m_active) begin
            m_t++;
            m_pulse = pulse_due(m_t);
        end
        m_inrep = m_active && (m_t >= RD);
        m_s2 = m_s1;
        m_s1 = b;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compare();
        chk("pulse", PULSE, m_pulse);
        chk("held", HELD, m_held);
        chk("repeating", REPEATING, m_rep);
    endtask

    task automatic tick();
        bit b, r;
        b = BTN_IN;
        r = RESET;
        @(posedge CLK100MHZ);
        #1;
        if (r) model_reset();
        else model_step(b);
        compare();
        if (PULSE === 1'b1) pulses++;
    endtask

    task automatic async_reset();
        RESET = 1'b1;
        #1;
        model_reset();
        compare();
    endtask

    task automatic release_btn();
        BTN_IN = 1'b0;
        repeat (12) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        model_reset();
        #2;
        // Reset held with button pressed: outputs stay 0, then press accepted.
        BTN_IN = 1'b1;
        async_reset();
        repeat (3) tick();
        RESET = 1'b0;
        pulses = 0;
        repeat (5) tick();
        chk_int("rst_no_early_pulse", pulses, 0);
        tick();
        chk("rst_pulse_edge6", PULSE, 1'b1);
        chk("rst_held_edge6", HELD, 1'b1);
        release_btn();

        // Glitch rejection, then a clean short press.
        pulses = 0;
        BTN_IN = 1'b1;
        repeat (3) tick();
        BTN_IN = 1'b0;
        repeat (10) tick();
        chk_int("glitch_pulses", pulses, 0);
        chk("glitch_held", HELD, 1'b0);
        BTN_IN = 1'b1;
        repeat (6) tick();
        chk_int("short_press_pulses", pulses, 1);
        release_btn();

        // Hold with repeat; HELD falls at T+37.
        pulses = 0;
        BTN_IN = 1'b1;
        repeat (6) tick();
        chk("hold_first_pulse", PULSE, 1'b1);
        repeat (31) tick();
        BTN_IN = 1'b0;
        repeat (12) tick();
        chk_int("hold_pulse_count", pulses, 5);

        // Release during DELAY, then re-press gets a full delay.
        pulses = 0;
        BTN_IN = 1'b1;
        repeat (12) tick();
        BTN_IN = 1'b0;
        repeat (12) tick();
        chk_int("delay_release_pulses", pulses, 1);
        pulses = 0;
        BTN_IN = 1'b1;
        repeat (25) tick();
        chk_int("repress_no_early", pulses, 1);
        tick();
        chk("repress_first_repeat", PULSE, 1'b1);
        release_btn();

        // Reset while in REPEAT at T+27.
        BTN_IN = 1'b1;
        repeat (33) tick();
        chk("rep_before_reset", REPEATING, 1'b1);
        async_reset();
        repeat (2) tick();
        RESET = 1'b0;
        pulses = 0;
        repeat (5) tick();
        chk_int("rst_rep_no_early", pulses, 0);
        tick();
        chk("rst_rep_pulse_edge6", PULSE, 1'b1);
        release_btn();

        // Long hold: repeat cadence over many periods.
        pulses = 0;
        BTN_IN = 1'b1;
        repeat (86) tick();
`ifdef BUTTON_AUTOREPEAT_ACCEL_EN
        chk_int("long_hold_pulses", pulses, 20);
`else
        chk_int("long_hold_pulses", pulses, 14);
`endif
        release_btn();

        // Random bouncing, holds and occasional resets.
        for (int i = 0; i < 60; i++) begin
            BTN_IN = 1'($urandom_range(0, 1));
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 45))
                                            : int'($urandom_range(1, 6));
            repeat (n) tick();
            if ($urandom_range(0, 19) == 0) begin
                async_reset();
                tick();
                RESET = 1'b0;
            end
        end
        release_btn();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
